ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, in, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, in, 1, reset, synchronous and active-high (RstEnable = 1).
REQ-003 SHALL have port stall, in, 6, pipeline stall vector from ctrl; bit 3 = EX stop.
REQ-004 SHALL have port aluop_i, in, 8, ALU operation code (AluOpBus).
REQ-005 SHALL have port alusel_i, in, 3, result-class selector (AluSelBus).
REQ-006 SHALL have ports reg1_i and reg2_i, in, 32 each, source operands (RegBus).
REQ-007 SHALL have port wd_i, in, 5, destination register address (RegAddrBus).
REQ-008 SHALL have port wreg_i, in, 1, destination write enable.
REQ-009 SHALL have ports wd_o (out, 5), wreg_o (out, 1) and wdata_o (out, 32), GPR writeback toward MEM.
REQ-010 SHALL have ports hi_o and lo_o (out, 32 each) and whilo_o (out, 1), HI/LO writeback toward MEM.
REQ-011 SHALL have port stallreq_o, out, 1, EX stall request to ctrl.

Function
REQ-012 SHALL compute logic ops (AND, OR, XOR, NOR, LUI via OR), shifts (SLL, SRL, SRA; amount = reg1_i[4:0]), ADD/ADDU/SUB/SUBU/SLT/SLTU combinationally, with wdata_o selected by alusel_i.
REQ-013 SHALL pass wd_o = wd_i, and SHALL drive wreg_o = wreg_i except on ADD/SUB signed overflow, where wreg_o = 0.
REQ-014 SHALL compute MULT/MULTU as a 64-bit combinational product, with hi_o = [63:32], lo_o = [31:0] and whilo_o = 1.
REQ-015 SHALL hold zero on all outputs in the same cycle as reset, and on hi_o/lo_o/whilo_o for non-HI/LO ops.
REQ-016 SHALL run a divider FSM with states IDLE, BUSY and DONE and a 6-bit iteration counter.
REQ-017 SHALL move IDLE to BUSY when aluop_i is DIV/DIVU and reg2_i != 0, latching operand magnitudes; stallreq_o = 1 in that cycle.
REQ-018 SHALL move IDLE to DONE when aluop_i is DIV/DIVU and reg2_i == 0; result is lo = 32'hFFFFFFFF, hi = reg1_i; stallreq_o = 1 in that cycle.
REQ-019 SHALL, in BUSY, perform one restoring shift-subtract step per clock, keep stallreq_o = 1, and move to DONE after exactly 32 steps.
REQ-020 SHALL, in DONE, drive stallreq_o = 0, lo_o = quotient, hi_o = remainder and whilo_o = 1.
REQ-021 SHALL, for DIV, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-022 SHALL move DONE to IDLE when stall[3] = NoStop, and SHALL hold DONE and its result while stall[3] = Stop.
REQ-023 SHALL abort to IDLE without a result if aluop_i leaves DIV/DIVU while in BUSY.
REQ-024 SHALL give a nonzero-divisor DIV/DIVU a latency of 33 cycles with stallreq_o high, with the result in cycle 34.
REQ-025 SHALL, on back-to-back divides, start the second only from IDLE, one cycle after DONE.

Reset
REQ-026 SHALL, when rst = 1 at a rising edge, force FSM = IDLE, counter = 0 and clear dividend/divisor/quotient registers, including mid-division; no partial result is emitted.
REQ-027 SHALL drive all outputs to zero while rst = 1: wd_o = NOPRegAddr, wreg_o = WriteDisable, stallreq_o = NoStop.

Configuration
REQ-028 SHALL, with EX_DIV_EN defined, implement the divider FSM as specified.
REQ-029 SHALL, with EX_DIV_EN undefined, omit the FSM and divider registers; DIV/DIVU then give whilo_o = 0, hi_o = lo_o = 0 and stallreq_o tied to 0.

Verification
REQ-030 Bench SHALL check ADD with reg1 = 32'h7FFFFFFF, reg2 = 1, wreg_i = 1 -> wreg_o = 0; ADDU on the same operands -> wdata_o = 32'h80000000, wreg_o = 1.
REQ-031 Bench SHALL check MULT with reg1 = -3, reg2 = 5 -> hi_o = 32'hFFFFFFFF, lo_o = 32'hFFFFFFF1, whilo_o = 1, same cycle.
REQ-032 Bench SHALL check DIV with reg1 = -7, reg2 = 2 -> stallreq_o high 33 cycles, then lo_o = 32'hFFFFFFFD, hi_o = 32'hFFFFFFFF, whilo_o = 1 for one cycle.
REQ-033 Bench SHALL check DIVU with reg1 = 100, reg2 = 0 -> stallreq_o high 1 cycle, then lo_o = 32'hFFFFFFFF, hi_o = 100.
REQ-034 Bench SHALL check DIVU 1000/7 with rst pulsed at BUSY step 10 -> FSM IDLE, whilo_o = 0; reissue -> lo_o = 142, hi_o = 6 after 33 cycles.
REQ-035 Bench SHALL check a DONE state held with stall[3] = 1 for 3 cycles -> result stable and whilo_o = 1 throughout, then IDLE.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX operand bundle and EX->MEM writeback bundle.
// slave is the execute stage; master is whoever feeds it and consumes results.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- logic, shift, add/sub/compare, 32x32 multiply.
// Define EX_DIV_EN to build the 32-step restoring divider FSM (DIV/DIVU).
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  ex_stage_if.slave  bus,
  output logic       stallreq_o
);
  localparam logic [7:0] OP_AND   = 8'b00100100;
  localparam logic [7:0] OP_OR    = 8'b00100101;
  localparam logic [7:0] OP_XOR   = 8'b00100110;
  localparam logic [7:0] OP_NOR   = 8'b00100111;
  localparam logic [7:0] OP_SLL   = 8'b01111100;
  localparam logic [7:0] OP_SRL   = 8'b00000010;
  localparam logic [7:0] OP_SRA   = 8'b00000011;
  localparam logic [7:0] OP_ADD   = 8'b00100000;
  localparam logic [7:0] OP_ADDU  = 8'b00100001;
  localparam logic [7:0] OP_SUB   = 8'b00100010;
  localparam logic [7:0] OP_SUBU  = 8'b00100011;
  localparam logic [7:0] OP_SLT   = 8'b00101010;
  localparam logic [7:0] OP_SLTU  = 8'b00101011;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic [31:0] r1;
  logic [31:0] r2;
  logic        is_sdiv;
  logic        is_div;
  logic        is_mul;

  assign r1      = bus.reg1_i;
  assign r2      = bus.reg2_i;
  assign is_sdiv = bus.aluop_i == OP_DIV;
  assign is_div  = is_sdiv || bus.aluop_i == OP_DIVU;
  assign is_mul  = bus.aluop_i == OP_MULT
                || bus.aluop_i == OP_MULTU;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] arith_res;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        is_sub;
  logic        ovf_kill;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    case (bus.aluop_i)
      OP_AND: logic_res = r1 & r2;
      OP_OR:  logic_res = r1 | r2;
      OP_XOR: logic_res = r1 ^ r2;
      OP_NOR: logic_res = ~(r1 | r2);
      OP_SLL: shift_res = r2 << r1[4:0];
      OP_SRL: shift_res = r2 >> r1[4:0];
      OP_SRA: shift_res = $signed(r2) >>> r1[4:0];
      default: ;
    endcase
  end

  // Subtract as r1 + ~r2 + 1 so one adder serves both directions.
  always_comb begin
    is_sub = bus.aluop_i == OP_SUB
          || bus.aluop_i == OP_SUBU;
    addend = is_sub ? ~r2 : r2;
    sum    = r1 + addend + {31'd0, is_sub};
    ovf_kill = (bus.aluop_i == OP_ADD
             || bus.aluop_i == OP_SUB)
             && (r1[31] == addend[31])
             && (sum[31] != r1[31]);
    arith_res = '0;
    case (bus.aluop_i)
      OP_ADD, OP_ADDU,
      OP_SUB, OP_SUBU: arith_res = sum;
      OP_SLT:  arith_res = {31'd0,
                 $signed(r1) < $signed(r2)};
      OP_SLTU: arith_res = {31'd0, r1 < r2};
      default: ;
    endcase
  end

  always_comb begin
    if (bus.aluop_i == OP_MULT) begin
      mul_a = {{32{r1[31]}}, r1};
      mul_b = {{32{r2[31]}}, r2};
    end else begin
      mul_a = {32'd0, r1};
      mul_b = {32'd0, r2};
    end
    prod = mul_a * mul_b;
  end

  logic        div_stall;
  logic        div_out;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [33:0] trial;

  assign a_neg = is_sdiv & r1[31];
  assign b_neg = is_sdiv & r2[31];
  assign a_mag = a_neg ? ~r1 + 32'd1 : r1;
  assign b_mag = b_neg ? ~r2 + 32'd1 : r2;
  assign rem_sh = {rem_q, dvd_q[31]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_stall = 1'b0;
    div_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          div_stall = 1'b1;
          if (r2 == 32'd0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = r1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            quo_d   = '0;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      S_BUSY: begin
        if (!is_div) begin
          state_d = S_IDLE;
        end else begin
          div_stall = 1'b1;
          dvd_d = dvd_q << 1;
          quo_d = {quo_q[30:0], ~trial[33]};
          rem_d = trial[33] ? rem_sh[31:0]
                            : trial[31:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_DONE;
        end
      end
      S_DONE: begin
        div_out = 1'b1;
        if (!stall[3]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_lo = qneg_q ? ~quo_q + 32'd1 : quo_q;
  assign div_hi = rneg_q ? ~rem_q + 32'd1 : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  logic div_unused;
  assign div_unused = ^{stall[5:4], stall[2:0], trial[32]};
`else
  assign div_stall = 1'b0;
  assign div_out   = 1'b0;
  assign div_hi    = '0;
  assign div_lo    = '0;

  logic div_unused;
  assign div_unused = ^{clk, stall, is_sdiv, is_div};
`endif

  always_comb begin
    bus.wd_o    = '0;
    bus.wreg_o  = 1'b0;
    bus.wdata_o = '0;
    bus.hi_o    = '0;
    bus.lo_o    = '0;
    bus.whilo_o = 1'b0;
    stallreq_o  = 1'b0;
    if (!rst) begin
      bus.wd_o   = bus.wd_i;
      bus.wreg_o = bus.wreg_i & ~ovf_kill;
      case (bus.alusel_i)
        SEL_LOGIC: bus.wdata_o = logic_res;
        SEL_SHIFT: bus.wdata_o = shift_res;
        SEL_ARITH: bus.wdata_o = arith_res;
        default: ;
      endcase
      if (div_out) begin
        bus.hi_o    = div_hi;
        bus.lo_o    = div_lo;
        bus.whilo_o = 1'b1;
      end else if (is_mul) begin
        bus.hi_o    = prod[63:32];
        bus.lo_o    = prod[31:0];
        bus.whilo_o = 1'b1;
      end
      stallreq_o = div_stall;
    end
  end
endmodule
